// File: rtl/warmboot_sequencer.sv
// Warm-boot sequencer for the iCE40 SB_WARMBOOT primitive.
// Waits out SPI traffic, detaches USB, settles the image select, then asserts BOOT.
module warmboot_sequencer #(
  parameter int unsigned DETACH_CYCLES = 48000,
  parameter int unsigned SETTLE_CYCLES = 48,
  parameter logic [1:0]  DEFAULT_IMAGE = 2'b01,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       cancel,
  input  logic       spi_busy,
  output logic       usb_pu,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SPI = 3'd1,
    S_DETACH   = 3'd2,
    S_SETTLE   = 3'd3,
    S_BOOT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       img_q, img_d;
  logic [1:0]       sel_q, sel_d;
  logic             pu_q, pu_d;
  logic             boot_q, boot_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    sel_d   = sel_q;
    pu_d    = pu_q;
    boot_d  = boot_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          img_d   = boot_image;
          state_d = S_WAIT_SPI;
          busy_d  = 1'b1;
        end
      end
      S_WAIT_SPI: begin
        if (cancel) begin
          state_d = S_IDLE;
          pu_d    = 1'b1;
          busy_d  = 1'b0;
        end else if (!spi_busy) begin
          state_d = S_DETACH;
          pu_d    = 1'b0;
          cnt_d   = DETACH_LOAD;
        end
      end
      S_DETACH: begin
        // A flash access during detach sends us back with no partial credit.
        if (cancel) begin
          state_d = S_IDLE;
          pu_d    = 1'b1;
          busy_d  = 1'b0;
        end else if (spi_busy) begin
          state_d = S_WAIT_SPI;
        end else if (cnt_zero) begin
          state_d = S_SETTLE;
          sel_d   = img_q;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          state_d = S_BOOT;
          boot_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_BOOT: begin
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        img_d   = DEFAULT_IMAGE;
        sel_d   = DEFAULT_IMAGE;
        pu_d    = 1'b1;
        boot_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      img_q   <= DEFAULT_IMAGE;
      sel_q   <= DEFAULT_IMAGE;
      pu_q    <= 1'b1;
      boot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      sel_q   <= sel_d;
      pu_q    <= pu_d;
      boot_q  <= boot_d;
      busy_q  <= busy_d;
    end
  end

  assign usb_pu    = pu_q;
  assign wb_s1     = sel_q[1];
  assign wb_s0     = sel_q[0];
  assign wb_boot   = boot_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
Sequences the iCE40 SB_WARMBOOT primitive for the bootloader top level. On a boot request, it waits for SPI flash traffic to finish and detaches USB by dropping the D+ pull-up. It then presents the selected image on S1/S0, lets them settle, and asserts BOOT. This gives the host a clean disconnect and ensures the configuration engine never reloads mid flash transaction.

Parameters:
DETACH_CYCLES, 48000, cycles usb_pu is held low before the image select is driven (1 ms at 48 MHz); must be >= 1
SETTLE_CYCLES, 48, cycles wb_s1/wb_s0 are held stable before wb_boot rises; must be >= 1
DEFAULT_IMAGE, 2'b01, wb_s1/wb_s0 value driven out of reset and while idle
CNT_W, 24, countdown counter width; must hold max(DETACH_CYCLES, SETTLE_CYCLES) - 1

Ports:
clk_48mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
boot_req  input  1  request pulse; sampled only in IDLE
boot_image  input  2  image select {S1,S0}; latched in the cycle boot_req is accepted
cancel  input  1  abort request; honoured in WAIT_SPI and DETACH only
spi_busy  input  1  high while a flash SPI transaction is in progress
usb_pu  output  1  USB D+ pull-up enable, feeds pin_pu
wb_s1  output  1  to SB_WARMBOOT S1
wb_s0  output  1  to SB_WARMBOOT S0
wb_boot  output  1  to SB_WARMBOOT BOOT
busy  output  1  high in every state except IDLE
state_dbg  output  3  encoded current state (IDLE=0, WAIT_SPI=1, DETACH=2, SETTLE=3, BOOT=4)

Behaviour:
- One clock domain (clk_48mhz). Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE, usb_pu = 1, {wb_s1,wb_s0} = DEFAULT_IMAGE
  - wb_boot = 0, busy = 0, counter = 0, latched image = DEFAULT_IMAGE
- Reset has priority over every state, including BOOT, and returns all outputs to their reset values the next cycle.
- IDLE:
  - boot_req = 1 latches boot_image and moves to WAIT_SPI; busy = 1 from the next cycle.
  - cancel is ignored in IDLE.
- WAIT_SPI:
  - cancel = 1 returns to IDLE; usb_pu = 1, busy = 0.
  - Otherwise, spi_busy = 0 moves to DETACH: usb_pu = 0, counter = DETACH_CYCLES - 1.
  - spi_busy = 1 holds the state indefinitely.
- DETACH:
  - Counter decrements each cycle.
  - cancel = 1 returns to IDLE; usb_pu = 1 next cycle. cancel has priority over spi_busy and counter expiry.
  - spi_busy = 1 returns to WAIT_SPI with usb_pu kept at 0. The counter is reloaded on re-entry to DETACH, so there is no partial credit.
  - Counter == 0 moves to SETTLE: {wb_s1,wb_s0} = latched image, counter = SETTLE_CYCLES - 1.
- SETTLE:
  - Committed: cancel, boot_req and spi_busy are ignored.
  - Counter == 0 moves to BOOT with wb_boot = 1.
- BOOT:
  - Terminal. wb_boot, usb_pu = 0 and the image select are held until reset.
- Simultaneous events:
  - boot_req together with cancel in IDLE: the request is accepted.
  - boot_req outside IDLE is dropped. There is no queueing.
- Image select is only driven from the latched value. A boot_image change after acceptance has no effect.
- Latency, with boot_req at cycle N and spi_busy = 0:
  - busy = 1 at N+1
  - usb_pu = 0 at N+2
  - wb_s1/wb_s0 valid at N+2+DETACH_CYCLES
  - wb_boot = 1 at N+2+DETACH_CYCLES+SETTLE_CYCLES
- wb_s1/wb_s0 never change in the same cycle wb_boot rises, and never change while wb_boot = 1.

Test Plan:
- Nominal (DETACH=8, SETTLE=4): boot_req=1, boot_image=2'b10 at cycle 10, spi_busy=0 -> busy=1 @11; usb_pu=0 @12; {s1,s0}=10 @20; wb_boot=1 @24 and held 50 cycles.
- SPI stall: spi_busy=1 for cycles 10-30, boot_req @10 -> state_dbg=1 through cycle 31; usb_pu=0 @32; wb_boot=1 @44.
- SPI re-busy in DETACH: spi_busy pulses high @15 -> state WAIT_SPI @16 with usb_pu=0; DETACH re-entered with a full 8-cycle count; wb_boot delayed accordingly.
- Cancel: cancel=1 @16 (in DETACH) -> state IDLE, usb_pu=1, busy=0 @17; {s1,s0} stays 01; wb_boot never rises. cancel @21 (SETTLE) is ignored and wb_boot=1 @24.
- Request filtering: second boot_req with image 11 @13 is dropped and the image stays 10. boot_image toggling after acceptance has no effect.
- Reset mid-sequence: reset @22 (SETTLE) and reset in BOOT -> next cycle usb_pu=1, wb_boot=0, {s1,s0}=01, state_dbg=0.
